// File: rtl/sobel_pkg.sv
// Shared constants and width helpers for the sobel_stream edge detector.
package sobel_pkg;
  localparam logic EDGE_ON        = 1'b0;
  localparam logic EDGE_OFF       = 1'b1;
  localparam int   DEFAULT_THRESH = 320;
  localparam int   LATENCY        = 5;

  function automatic int grad_w(input int pix_w);
    return pix_w + 3;
  endfunction

  function automatic int abs_w(input int pix_w);
    return pix_w + 2;
  endfunction
endpackage

// File: rtl/sobel_line_buf.sv
// One line of pixel history: simple dual-port RAM with a registered read port.
module sobel_line_buf
  import sobel_pkg::*;
#(
  parameter int PIX_W    = 8,
  parameter int LINE_MAX = 1024,
  parameter int COL_W    = 10
) (
  input  logic             clock,
  input  logic             rd_en,
  input  logic [COL_W-1:0] rd_addr,
  output logic [PIX_W-1:0] rd_data,
  input  logic             wr_en,
  input  logic [COL_W-1:0] wr_addr,
  input  logic [PIX_W-1:0] wr_data
);
  logic [PIX_W-1:0] mem [LINE_MAX];

  // A read and a write to the same address in one cycle return the old word.
  always_ff @(posedge clock) begin
    if (rd_en) rd_data <= mem[rd_addr];
    if (wr_en) mem[wr_addr] <= wr_data;
  end
endmodule

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge detector, |Gx|+|Gy| against a per-frame threshold.
// Optional SOBEL_MAG_OUT_EN adds the saturated magnitude output mag_out.
module sobel_stream
  import sobel_pkg::*;
#(
  parameter int PIX_W    = 8,
  parameter int LINE_MAX = 1024,
  parameter int COL_W    = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_valid,
  input  logic             pix_sol,
  input  logic             pix_sof,
  input  logic [PIX_W+2:0] threshold,
  output logic [PIX_W-1:0] edge_out,
  output logic             edge_valid,
  output logic             line_ovf
`ifdef SOBEL_MAG_OUT_EN
  ,
  output logic [PIX_W-1:0] mag_out
`endif
);
  localparam int GW = grad_w(PIX_W);
  localparam int AW = abs_w(PIX_W);
  localparam logic [PIX_W-1:0] PIX_OFF    = {PIX_W{EDGE_OFF}};
  localparam logic [PIX_W-1:0] PIX_ON     = {PIX_W{EDGE_ON}};
  localparam logic [COL_W-1:0] LAST_COL   = COL_W'(LINE_MAX - 1);
  localparam logic [GW-1:0]    THRESH_RST = GW'(DEFAULT_THRESH);

  function automatic logic signed [GW-1:0] widen(input logic [PIX_W-1:0] p);
    return $signed({{(GW-PIX_W){1'b0}}, p});
  endfunction

  function automatic logic [AW-1:0] abs_grad(input logic signed [GW-1:0] g);
    return (g < 0) ? AW'(-g) : AW'(g);
  endfunction

`ifdef SOBEL_MAG_OUT_EN
  function automatic logic [PIX_W-1:0] sat_mag(input logic [GW-1:0] s);
    logic [GW-1:0] q;
    q = s >> 3;
    return (|q[GW-1:PIX_W]) ? {PIX_W{1'b1}} : q[PIX_W-1:0];
  endfunction
`endif

  logic [COL_W-1:0] col_reg, col_nxt, col_p1;
  logic [1:0]       row_reg, row_nxt;
  logic             ovf_hit, border_nxt;
  logic [GW-1:0]    thr_reg, thr_p1, thr_p2, thr_p3, thr_p4;
  logic             vld_p1, vld_p2, vld_p3, vld_p4;
  logic             brd_p1, brd_p2, brd_p3, brd_p4;
  logic [PIX_W-1:0] pix_p1, rd0, rd1;
  logic [PIX_W-1:0] win_p2 [9];
  logic signed [GW-1:0] ext [9];
  logic signed [GW-1:0] gx_p3, gy_p3;
  logic [AW-1:0]    ax_p4, ay_p4;
  logic [GW-1:0]    sum;

  // Position of the incoming pixel; row saturates at 3 since only r<2 matters.
  always_comb begin
    col_nxt = col_reg + COL_W'(1);
    row_nxt = row_reg;
    ovf_hit = 1'b0;
    if (pix_sof) begin
      col_nxt = '0;
      row_nxt = '0;
    end else if (pix_sol) begin
      col_nxt = '0;
      if (row_reg != 2'd3) row_nxt = row_reg + 2'd1;
    end else if (col_reg == LAST_COL) begin
      col_nxt = col_reg;
      ovf_hit = 1'b1;
    end
    border_nxt = (row_nxt < 2'd2) || (col_nxt < COL_W'(2));
  end

  // Line 1 is fed from line 0's read port one cycle later, so it holds row r-2.
  sobel_line_buf #(.PIX_W(PIX_W), .LINE_MAX(LINE_MAX), .COL_W(COL_W)) u_line0 (
    .clock(clock), .rd_en(pix_valid), .rd_addr(col_nxt), .rd_data(rd0),
    .wr_en(pix_valid), .wr_addr(col_nxt), .wr_data(pix_in)
  );

  sobel_line_buf #(.PIX_W(PIX_W), .LINE_MAX(LINE_MAX), .COL_W(COL_W)) u_line1 (
    .clock(clock), .rd_en(pix_valid), .rd_addr(col_nxt), .rd_data(rd1),
    .wr_en(vld_p1), .wr_addr(col_p1), .wr_data(rd0)
  );

  always_comb begin
    for (int i = 0; i < 9; i++) ext[i] = widen(win_p2[i]);
    sum = GW'(ax_p4) + GW'(ay_p4);
  end

  always_ff @(posedge clock) begin
    // S1: pixel, position flags and the threshold this pixel will be judged by
    pix_p1 <= pix_in;
    col_p1 <= col_nxt;
    brd_p1 <= border_nxt;
    thr_p1 <= pix_sof ? threshold : thr_reg;
    // S2: shift the new column (r-2, r-1, r) into the window
    if (vld_p1) begin
      win_p2[0] <= win_p2[1]; win_p2[1] <= win_p2[2]; win_p2[2] <= rd1;
      win_p2[3] <= win_p2[4]; win_p2[4] <= win_p2[5]; win_p2[5] <= rd0;
      win_p2[6] <= win_p2[7]; win_p2[7] <= win_p2[8]; win_p2[8] <= pix_p1;
    end
    brd_p2 <= brd_p1;
    thr_p2 <= thr_p1;
    // S3: gradients
    gx_p3 <= (ext[2] - ext[0]) + ((ext[5] - ext[3]) <<< 1) + (ext[8] - ext[6]);
    gy_p3 <= (ext[0] - ext[6]) + ((ext[1] - ext[7]) <<< 1) + (ext[2] - ext[8]);
    brd_p3 <= brd_p2;
    thr_p3 <= thr_p2;
    // S4: magnitudes
    ax_p4  <= abs_grad(gx_p3);
    ay_p4  <= abs_grad(gy_p3);
    brd_p4 <= brd_p3;
    thr_p4 <= thr_p3;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      col_reg    <= '0;
      row_reg    <= '0;
      line_ovf   <= 1'b0;
      thr_reg    <= THRESH_RST;
      vld_p1     <= 1'b0;
      vld_p2     <= 1'b0;
      vld_p3     <= 1'b0;
      vld_p4     <= 1'b0;
      edge_valid <= 1'b0;
      edge_out   <= PIX_OFF;
    end else begin
      vld_p1     <= pix_valid;
      vld_p2     <= vld_p1;
      vld_p3     <= vld_p2;
      vld_p4     <= vld_p3;
      edge_valid <= vld_p4;
      if (pix_valid) begin
        col_reg <= col_nxt;
        row_reg <= row_nxt;
        if (pix_sof) begin
          thr_reg  <= threshold;
          line_ovf <= 1'b0;
        end else if (ovf_hit) begin
          line_ovf <= 1'b1;
        end
      end
      // S5: strict compare, border pixels never report an edge
      if (vld_p4) edge_out <= (!brd_p4 && (sum > thr_p4)) ? PIX_ON : PIX_OFF;
    end
  end

`ifdef SOBEL_MAG_OUT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset)       mag_out <= '0;
    else if (vld_p4) mag_out <= brd_p4 ? '0 : sat_mag(sum);
  end
`endif
endmodule

// File: tb/tb_sobel_stream.sv
// Directed bench for sobel_stream: flat, step, gapped, threshold, overflow and reset cases.
module tb_sobel_stream;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  pix_in = '0;
  logic        pix_valid = 1'b0;
  logic        pix_sol = 1'b0;
  logic        pix_sof = 1'b0;
  logic [10:0] threshold = 11'd320;
  logic [7:0]  edge_out;
  logic        edge_valid;
  logic        line_ovf;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int in_t[$];
  int out_t[$];
  logic [7:0] exp_v[$];
  logic [7:0] out_v[$];

  sobel_stream #(.PIX_W(8), .LINE_MAX(1024), .COL_W(10)) dut (
    .clock(clock), .reset(reset), .pix_in(pix_in), .pix_valid(pix_valid),
    .pix_sol(pix_sol), .pix_sof(pix_sof), .threshold(threshold),
    .edge_out(edge_out), .edge_valid(edge_valid), .line_ovf(line_ovf)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (edge_valid === 1'b1) begin
      out_t.push_back(cyc);
      out_v.push_back(edge_out);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // 0: flat 100; 1: columns >=4 at 255; 2: columns >=4 at 20
  function automatic logic [7:0] pix_of(input int kind, input int c);
    if (kind == 0) return 8'd100;
    if (c < 4) return 8'd0;
    return (kind == 1) ? 8'd255 : 8'd20;
  endfunction

  function automatic int sum_of(input int kind, input int c);
    if (kind == 0 || !(c == 4 || c == 5)) return 0;
    return (kind == 1) ? 1020 : 80;
  endfunction

  function automatic logic [7:0] exp_of(input int kind, input int r, input int c, input int thr);
    if (r < 2 || c < 2) return 8'hFF;
    return (sum_of(kind, c) > thr) ? 8'h00 : 8'hFF;
  endfunction

  task automatic drive(input logic [7:0] p, input logic sol, input logic sof,
                       input logic [7:0] e, input bit track);
    @(posedge clock); #1;
    pix_in = p; pix_valid = 1'b1; pix_sol = sol; pix_sof = sof;
    if (track) begin
      in_t.push_back(cyc);
      exp_v.push_back(e);
    end
  endtask

  // Idle cycles carry random sol/sof and data, which must all be ignored.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock); #1;
      pix_valid = 1'b0;
      pix_sol = 1'($urandom_range(0, 1));
      pix_sof = 1'($urandom_range(0, 1));
      pix_in = 8'($urandom);
    end
  endtask

  task automatic send_frame(input int kind, input int rows, input int cols, input int thr,
                            input bit gap, input int mid_at, input int thr_mid);
    threshold = 11'(thr);
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < cols; c++) begin
        if (r * cols + c == mid_at) threshold = 11'(thr_mid);
        drive(pix_of(kind, c), c == 0, (r == 0 && c == 0), exp_of(kind, r, c, thr), 1'b1);
        if (gap) idle(2);
      end
    end
  endtask

  task automatic clear_q();
    in_t.delete(); exp_v.delete(); out_t.delete(); out_v.delete();
  endtask

  task automatic check_outputs(input string tag);
    int n;
    idle(12);
    chk({tag, " count"}, out_t.size(), in_t.size());
    n = (out_t.size() < in_t.size()) ? out_t.size() : in_t.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s latency[%0d]", tag, i), out_t[i] - in_t[i], 5);
      chk($sformatf("%s value[%0d]", tag, i), out_v[i], exp_v[i]);
    end
    clear_q();
  endtask

  initial begin
    bit found;
    repeat (3) @(posedge clock);
    #1;
    chk("reset edge_valid", edge_valid, 0);
    chk("reset edge_out", edge_out, 8'hFF);
    chk("reset line_ovf", line_ovf, 0);
    reset = 1'b0;

    send_frame(0, 8, 8, 320, 1'b0, -1, 0);
    check_outputs("flat");
    send_frame(1, 8, 8, 320, 1'b0, -1, 0);
    check_outputs("step320");
    send_frame(1, 8, 8, 1020, 1'b0, -1, 0);
    check_outputs("step1020");
    send_frame(1, 8, 8, 320, 1'b1, -1, 0);
    check_outputs("gapped");

    // Mid-frame change must wait for the next sof; frames run back to back.
    send_frame(2, 8, 8, 320, 1'b0, 20, 0);
    send_frame(2, 8, 8, 0, 1'b0, -1, 0);
    check_outputs("thresh");

    threshold = 11'd320;
    drive(8'd100, 1'b1, 1'b1, 8'hFF, 1'b1);
    for (int k = 1; k < 1024; k++) drive(8'd100, 1'b0, 1'b0, 8'hFF, 1'b1);
    idle(1);
    chk("ovf clear at LINE_MAX", line_ovf, 0);
    for (int k = 0; k < 3; k++) drive(8'd100, 1'b0, 1'b0, 8'hFF, 1'b1);
    idle(1);
    chk("ovf set", line_ovf, 1);
    for (int c = 0; c < 8; c++) drive(8'd100, c == 0, 1'b0, 8'hFF, 1'b1);
    idle(1);
    chk("ovf sticky", line_ovf, 1);
    check_outputs("ovf");
    send_frame(0, 4, 8, 320, 1'b0, -1, 0);
    check_outputs("after_ovf");
    chk("ovf cleared by sof", line_ovf, 0);

    found = 1'b0;
    threshold = 11'd320;
    for (int i = 0; i < 64 && !found; i++) begin
      drive(pix_of(1, i % 8), (i % 8) == 0, i == 0, 8'hFF, 1'b0);
      if (edge_valid === 1'b1 && edge_out === 8'h00) found = 1'b1;
    end
    chk("edge seen before reset", found, 1);
    #2 reset = 1'b1;
    pix_valid = 1'b0;
    #1;
    chk("async reset edge_valid", edge_valid, 0);
    chk("async reset edge_out", edge_out, 8'hFF);
    idle(3);
    reset = 1'b0;
    clear_q();
    send_frame(1, 8, 8, 320, 1'b0, -1, 0);
    check_outputs("post_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
